scan_beta_update: RTL and testbench

Pipelined SCAN beta-update stage sitting directly upstream of the decoder's beta (b) memory. Each beat combines P child betas (left/right) with P left/right LLRs into 2·P parent betas and presents them, with the matching write layer/count tags and write enable, in the exact packed format the b-memory write port consumes. It also tracks multi-beat layers, flags out-of-order beats, and pulses a per-layer completion strobe for the decoder scheduler.

---
 rtl/scan_beta_update.sv | 207 ++++++++++++++++++++
 tb/tb_scan_beta_update.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_beta_update.sv
// SCAN beta-update stage feeding the b-memory write port; 2-cycle latency, one beat per cycle.
// No backpressure: every in_valid beat is accepted. SCAN_BETA_SAT_EN selects symmetric saturation over wrap.
module scan_beta_update #(
   parameter int Q = 6,
   parameter int P = 64,
   parameter int N = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [4:0]       in_layer,
   input  logic [3:0]       in_cnt,
   input  logic [P*Q-1:0]   b_l,
   input  logic [P*Q-1:0]   b_r,
   input  logic [P*Q-1:0]   l_l,
   input  logic [P*Q-1:0]   l_r,
   input  logic             flush,
   output logic [2*P*Q-1:0] b_wdata,
   output logic             w_en,
   output logic [4:0]       layer_w,
   output logic [3:0]       cnta,
   output logic             layer_done,
   output logic             seq_err,
   output logic             busy
);

   localparam int W  = P * Q;
   localparam int WE = P * (Q + 1);
   localparam int L8_BEATS = (N / (8 * P) > 1) ? N / (8 * P) : 1;
   localparam logic [3:0] L8_LAST = 4'(L8_BEATS - 1);

   // g(a,b): sign-corrected minimum magnitude; zero counts as positive
   function automatic logic signed [Q:0] g_fn(input logic signed [Q:0] a,
                                              input logic signed [Q:0] b);
      logic [Q:0] ma;
      logic [Q:0] mb;
      logic [Q:0] m;
      ma = a[Q] ? $unsigned(-a) : $unsigned(a);
      mb = b[Q] ? $unsigned(-b) : $unsigned(b);
      m  = (ma < mb) ? ma : mb;
      return (a[Q] ^ b[Q]) ? -$signed(m) : $signed(m);
   endfunction

`ifdef SCAN_BETA_SAT_EN
   localparam logic signed [Q+1:0] SAT_HI = (Q+2)'((1 << (Q - 1)) - 1);
   localparam logic signed [Q+1:0] SAT_LO = -SAT_HI;

   function automatic logic [Q-1:0] reduce(input logic signed [Q+1:0] x);
      if (x > SAT_HI)
         return SAT_HI[Q-1:0];
      else if (x < SAT_LO)
         return SAT_LO[Q-1:0];
      else
         return x[Q-1:0];
   endfunction
`else
   function automatic logic [Q-1:0] reduce(input logic signed [Q+1:0] x);
      return x[Q-1:0];
   endfunction
`endif

   logic            s1_vld;
   logic [4:0]      s1_layer;
   logic [3:0]      s1_cnt;
   logic [W-1:0]    s1_bl;
   logic [W-1:0]    s1_ll;
   logic [WE-1:0]   s1_s;
   logic [WE-1:0]   s1_br;

   logic            s2_vld;
   logic [4:0]      s2_layer;
   logic [3:0]      s2_cnt;
   logic [W-1:0]    s2_lo;
   logic [W-1:0]    s2_hi;

   logic [WE-1:0]   s_in;
   logic [WE-1:0]   br_in;
   logic [W-1:0]    lo_res;
   logic [W-1:0]    hi_res;

   logic [3:0]      exp_cnt;
   logic [3:0]      exp_nxt;
   logic            wr;
   logic            done;
   logic            err;

   for (genvar i = 0; i < P; i++) begin : g_lane
      logic signed [Q:0]   br_e;
      logic signed [Q:0]   lr_e;
      logic signed [Q:0]   bl_e;
      logic signed [Q:0]   ll_e;
      logic signed [Q:0]   s_e;
      logic signed [Q:0]   br_s;
      logic signed [Q:0]   g_lo;
      logic signed [Q:0]   g_hi;
      logic signed [Q+1:0] lo_w;
      logic signed [Q+1:0] hi_w;

      assign br_e = {b_r[i*Q+Q-1], b_r[i*Q +: Q]};
      assign lr_e = {l_r[i*Q+Q-1], l_r[i*Q +: Q]};
      assign s_in[i*(Q+1) +: Q+1]  = br_e + lr_e;
      assign br_in[i*(Q+1) +: Q+1] = br_e;

      assign bl_e = {s1_bl[i*Q+Q-1], s1_bl[i*Q +: Q]};
      assign ll_e = {s1_ll[i*Q+Q-1], s1_ll[i*Q +: Q]};
      assign s_e  = s1_s[i*(Q+1) +: Q+1];
      assign br_s = s1_br[i*(Q+1) +: Q+1];

      assign g_lo = g_fn(bl_e, s_e);
      assign g_hi = g_fn(bl_e, ll_e);
      assign lo_w = {g_lo[Q], g_lo};
      assign hi_w = {g_hi[Q], g_hi} + {br_s[Q], br_s};

      assign lo_res[i*Q +: Q] = reduce(lo_w);
      assign hi_res[i*Q +: Q] = reduce(hi_w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld   <= 1'b0;
         s1_layer <= '0;
         s1_cnt   <= '0;
         s1_bl    <= '0;
         s1_ll    <= '0;
         s1_s     <= '0;
         s1_br    <= '0;
         s2_vld   <= 1'b0;
         s2_layer <= '0;
         s2_cnt   <= '0;
         s2_lo    <= '0;
         s2_hi    <= '0;
      end else begin
         s1_vld <= in_valid & ~flush;
         s2_vld <= s1_vld & ~flush;
         if (in_valid) begin
            s1_layer <= in_layer;
            s1_cnt   <= in_cnt;
            s1_bl    <= b_l;
            s1_ll    <= l_l;
            s1_s     <= s_in;
            s1_br    <= br_in;
         end
         if (s1_vld) begin
            s2_layer <= s1_layer;
            s2_cnt   <= s1_cnt;
            s2_lo    <= lo_res;
            s2_hi    <= hi_res;
         end
      end
   end

   // Layer 8 spans several beats and must arrive in count order; other valid layers complete per beat
   always_comb begin
      wr      = 1'b0;
      done    = 1'b0;
      err     = seq_err;
      exp_nxt = exp_cnt;
      if (flush) begin
         exp_nxt = '0;
      end else if (s2_vld) begin
         if (s2_layer == 5'd8) begin
            wr = 1'b1;
            if (s2_cnt == exp_cnt) begin
               if (exp_cnt == L8_LAST) begin
                  done    = 1'b1;
                  exp_nxt = '0;
               end else begin
                  exp_nxt = exp_cnt + 4'd1;
               end
            end else begin
               err     = 1'b1;
               exp_nxt = '0;
            end
         end else if (s2_layer != 5'd0 && s2_layer < 5'd8) begin
            wr   = 1'b1;
            done = 1'b1;
         end else begin
            err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_wdata    <= '0;
         w_en       <= 1'b0;
         layer_w    <= '0;
         cnta       <= '0;
         layer_done <= 1'b0;
         seq_err    <= 1'b0;
         exp_cnt    <= '0;
      end else begin
         w_en       <= wr;
         layer_done <= done;
         seq_err    <= err;
         exp_cnt    <= exp_nxt;
         if (wr) begin
            b_wdata <= {s2_hi, s2_lo};
            layer_w <= s2_layer;
            cnta    <= s2_cnt;
         end
      end
   end

   assign busy = ~rst & (s1_vld | s2_vld | in_valid);

endmodule

// File: tb/tb_scan_beta_update.sv
// Randomized bench for scan_beta_update against a beat-history reference model.
module tb_scan_beta_update;

   localparam int Q = 6;
   localparam int P = 64;
   localparam int N = 1024;
   localparam int W = P * Q;

   typedef struct packed {
      logic [4:0]   layer;
      logic [3:0]   cnt;
      logic [W-1:0] bl;
      logic [W-1:0] br;
      logic [W-1:0] ll;
      logic [W-1:0] lr;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [4:0]     in_layer = '0;
   logic [3:0]     in_cnt = '0;
   logic [W-1:0]   b_l = '0;
   logic [W-1:0]   b_r = '0;
   logic [W-1:0]   l_l = '0;
   logic [W-1:0]   l_r = '0;
   logic           flush = 1'b0;
   logic [2*W-1:0] b_wdata;
   logic           w_en;
   logic [4:0]     layer_w;
   logic [3:0]     cnta;
   logic           layer_done;
   logic           seq_err;
   logic           busy;

   int checks = 0;
   int failures = 0;
   int wen_seen = 0;

   scan_beta_update #(.Q(Q), .P(P), .N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_layer(in_layer), .in_cnt(in_cnt),
      .b_l(b_l), .b_r(b_r), .l_l(l_l), .l_r(l_r), .flush(flush),
      .b_wdata(b_wdata), .w_en(w_en), .layer_w(layer_w), .cnta(cnta),
      .layer_done(layer_done), .seq_err(seq_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sx(input logic [Q-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int gfun(input int a, input int b);
      int ma, mb, m;
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      m  = (ma < mb) ? ma : mb;
      return ((a < 0) != (b < 0)) ? -m : m;
   endfunction

   function automatic int red(input int x);
`ifdef SCAN_BETA_SAT_EN
      if (x > 31) return 31;
      if (x < -31) return -31;
`endif
      return x;
   endfunction

   function automatic logic [2*W-1:0] exp_wdata(input beat_t b);
      logic [2*W-1:0] r;
      int a, s, lo, hi;
      r = '0;
      for (int i = 0; i < P; i++) begin
         a  = sx(b.bl[i*Q +: Q]);
         s  = sx(b.br[i*Q +: Q]) + sx(b.lr[i*Q +: Q]);
         lo = red(gfun(a, s));
         hi = red(gfun(a, sx(b.ll[i*Q +: Q])) + sx(b.br[i*Q +: Q]));
         r[i*Q +: Q]     = lo[Q-1:0];
         r[(P+i)*Q +: Q] = hi[Q-1:0];
      end
      return r;
   endfunction

   // h0: beat accepted at the latest edge, h1: the one before; a beat is written two edges after acceptance
   logic           h_vld0 = 1'b0, h_vld1 = 1'b0;
   beat_t          h_b0 = '0, h_b1 = '0;
   int             m_exp = 0;
   logic           m_err = 1'b0, m_wen = 1'b0, m_done = 1'b0;
   logic [2*W-1:0] m_wdata = '0;
   logic [4:0]     m_layer = '0;
   logic [3:0]     m_cnt = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h_vld0 <= 1'b0; h_vld1 <= 1'b0; m_exp <= 0; m_err <= 1'b0;
         m_wen <= 1'b0; m_done <= 1'b0; m_wdata <= '0; m_layer <= '0; m_cnt <= '0;
      end else begin
         m_wen  <= 1'b0;
         m_done <= 1'b0;
         if (flush) begin
            h_vld0 <= 1'b0; h_vld1 <= 1'b0; m_exp <= 0;
         end else begin
            h_vld0 <= in_valid;
            h_b0   <= {in_layer, in_cnt, b_l, b_r, l_l, l_r};
            h_vld1 <= h_vld0;
            h_b1   <= h_b0;
            if (h_vld1) begin
               if (h_b1.layer >= 1 && h_b1.layer <= 8) begin
                  m_wen <= 1'b1;
                  m_wdata <= exp_wdata(h_b1);
                  m_layer <= h_b1.layer;
                  m_cnt <= h_b1.cnt;
                  if (h_b1.layer != 8) m_done <= 1'b1;
                  else if (int'(h_b1.cnt) != m_exp) begin m_err <= 1'b1; m_exp <= 0; end
                  else if (m_exp == 1) begin m_done <= 1'b1; m_exp <= 0; end
                  else m_exp <= m_exp + 1;
               end else begin
                  m_err <= 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("w_en", w_en, m_wen);
      chk("layer_done", layer_done, m_done);
      chk("seq_err", seq_err, m_err);
      chk("busy", busy, !rst && (h_vld0 || h_vld1 || in_valid));
      chk("b_wdata", b_wdata, m_wdata);
      chk("layer_w", layer_w, m_layer);
      chk("cnta", cnta, m_cnt);
      wen_seen <= wen_seen + (w_en ? 1 : 0);
   end

   // ---------------- stimulus ----------------
   function automatic logic [Q-1:0] pick();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return 6'h20;
      if (r == 1) return 6'h1F;
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic rand_data();
      for (int i = 0; i < P; i++) begin
         b_l[i*Q +: Q] = pick();
         b_r[i*Q +: Q] = pick();
         l_l[i*Q +: Q] = pick();
         l_r[i*Q +: Q] = pick();
      end
   endtask

   task automatic step(input logic v, input logic [4:0] ly, input logic [3:0] c, input logic fl);
      in_valid = v; in_layer = ly; in_cnt = c; flush = fl;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_wdata", b_wdata, '0);
      chk("rst_wen", w_en, 1'b0);
      chk("rst_layer_w", layer_w, 5'd0);
      chk("rst_cnta", cnta, 4'd0);
      chk("rst_done", layer_done, 1'b0);
      chk("rst_seq_err", seq_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int start;
      logic [4:0] ly;
      logic [3:0] c;
      int r;

      repeat (3) @(posedge clk);
      #1;
      chk("init_wen", w_en, 1'b0);
      chk("init_busy", busy, 1'b0);
      chk("init_wdata", b_wdata, '0);
      rst = 1'b0;

      // layer 5 directed lane-0 values
      rand_data();
      b_l[5:0] = 6'd5; b_r[5:0] = 6'd3; l_r[5:0] = 6'h36; l_l[5:0] = 6'd7;
      step(1'b1, 5'd5, 4'd0, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l5_not_yet", w_en, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l5_wen", w_en, 1'b1);
      chk("l5_layer", layer_w, 5'd5);
      chk("l5_lane0", b_wdata[0 +: Q], 6'h3B);
      chk("l5_lane64", b_wdata[W +: Q], 6'd8);
      chk("l5_done", layer_done, 1'b1);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l5_one_cycle", w_en, 1'b0);
      chk("l5_hold_lane0", b_wdata[0 +: Q], 6'h3B);

      // lane 0 all at positive full scale
      rand_data();
      b_l[5:0] = 6'h1F; b_r[5:0] = 6'h1F; l_l[5:0] = 6'h1F; l_r[5:0] = 6'h1F;
      step(1'b1, 5'd3, 4'd0, 1'b0);
      repeat (2) step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("sat_lane0", b_wdata[0 +: Q], 6'h1F);
`ifdef SCAN_BETA_SAT_EN
      chk("sat_lane64", b_wdata[W +: Q], 6'h1F);
`else
      chk("wrap_lane64", b_wdata[W +: Q], 6'h3E);
`endif

      // layer 8 in order, then an out-of-order beat
      rand_data();
      step(1'b1, 5'd8, 4'd0, 1'b0);
      rand_data();
      step(1'b1, 5'd8, 4'd1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l8_b0_wen", w_en, 1'b1);
      chk("l8_b0_done", layer_done, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l8_b1_wen", w_en, 1'b1);
      chk("l8_b1_done", layer_done, 1'b1);
      chk("l8_b1_cnta", cnta, 4'd1);
      step(1'b1, 5'd8, 4'd1, 1'b0);
      repeat (2) step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l8_ooo_wen", w_en, 1'b1);
      chk("l8_ooo_done", layer_done, 1'b0);
      chk("l8_ooo_err", seq_err, 1'b1);

      // flush one cycle after the third of three beats
      do_reset();
      start = wen_seen;
      rand_data();
      step(1'b1, 5'd8, 4'd0, 1'b0);
      step(1'b1, 5'd3, 4'd0, 1'b0);
      step(1'b1, 5'd4, 4'd0, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1);
      repeat (3) step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("flush_wen_count", 32'(wen_seen - start), 32'd1);
      chk("flush_busy", busy, 1'b0);
      step(1'b1, 5'd8, 4'd0, 1'b0);
      step(1'b1, 5'd8, 4'd1, 1'b0);
      repeat (2) step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("flush_exp_done", layer_done, 1'b1);
      chk("flush_exp_err", seq_err, 1'b0);

      // illegal layer
      step(1'b1, 5'd9, 4'd0, 1'b0);
      repeat (2) step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l9_wen", w_en, 1'b0);
      chk("l9_err", seq_err, 1'b1);
      step(1'b0, 5'd0, 4'd0, 1'b1);
      step(1'b0, 5'd0, 4'd0, 1'b0);
      chk("l9_err_after_flush", seq_err, 1'b1);
      do_reset();
      chk("l9_err_after_rst", seq_err, 1'b0);

      // random traffic
      for (int n = 0; n < 2500; n++) begin
         rand_data();
         r = $urandom_range(0, 9);
         if (r < 4) ly = 5'd8;
         else if (r < 9) ly = 5'($urandom_range(1, 7));
         else ly = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(9, 31));
         c = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) do_reset();
         step($urandom_range(0, 3) != 0, ly, c, $urandom_range(0, 31) == 0);
      end
      repeat (4) step(1'b0, 5'd0, 4'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
